// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter between the CPU data port
// and the game/display port.
package ram_arb_pkg;

    localparam int PORT_CPU           = 0;
    localparam int PORT_GAME          = 1;
    localparam int DEFAULT_MAX_WAIT   = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_GAME = 2'd2
    } win_t;

    function automatic int wait_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: command, grant and read-return signals
// for both ports.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                     req0;
    logic                     req1;
    logic                     we0;
    logic                     we1;
    logic [ADDRESS_WIDTH-1:0] addr0;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0]    wdata0;
    logic [DATA_WIDTH-1:0]    wdata1;
    logic                     gnt0;
    logic                     gnt1;
    logic                     rvalid0;
    logic                     rvalid1;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface

// File: rtl/ram_arb_wait_counter.sv
// Saturating count of consecutive cycles the game port has been denied;
// sat tells the arbiter to force the game port through.
module ram_arb_wait_counter
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CW       = wait_width(MAX_WAIT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          sat
);

    assign sat = (count == CW'(MAX_WAIT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (fixed priority) and the
// game/display port, with a bounded wait that guarantees the game port progress.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_WAIT      = DEFAULT_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     resetn,
    ram_arbiter_if.slave             bus,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam int CW = wait_width(MAX_WAIT);

    win_t          win;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [CW-1:0] w1;
    logic          w1_sat;

    // Grants are forced low while reset is asserted, independent of requests.
    always_comb begin
        win = WIN_NONE;
        if (resetn) begin
            if (bus.req0 && !(bus.req1 && w1_sat)) begin
                win = WIN_CPU;
            end else if (bus.req1) begin
                win = WIN_GAME;
            end
        end
    end

    assign gnt[PORT_CPU]  = (win == WIN_CPU);
    assign gnt[PORT_GAME] = (win == WIN_GAME);

    // With no grant the RAM sees port 0's address; the read is discarded.
    always_comb begin
        ram_addr   = bus.addr0;
        ram_dataIn = bus.wdata0;
        ram_wEn    = gnt[PORT_CPU] & bus.we0;
        if (win == WIN_GAME) begin
            ram_addr   = bus.addr1;
            ram_dataIn = bus.wdata1;
            ram_wEn    = bus.we1;
        end
    end

    ram_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_wait_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (bus.req1 & ~gnt[PORT_GAME]),
        .clr    (gnt[PORT_GAME] | ~bus.req1),
        .count  (w1),
        .sat    (w1_sat)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= '0;
        end else begin
            rvalid[PORT_CPU]  <= gnt[PORT_CPU]  & ~bus.we0;
            rvalid[PORT_GAME] <= gnt[PORT_GAME] & ~bus.we1;
        end
    end

    assign bus.gnt0    = gnt[PORT_CPU];
    assign bus.gnt1    = gnt[PORT_GAME];
    assign bus.rvalid0 = rvalid[PORT_CPU];
    assign bus.rvalid1 = rvalid[PORT_GAME];
    assign bus.rdata   = ram_dataOut;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter against a registered-read RAM model
// and a reference memory.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;
    logic [DW-1:0] ram_mem [0:4095];

    int tests = 0;
    int fails = 0;

    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    ram_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MAX_WAIT      (MW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut)
    );

    always #5 clk = ~clk;

    // Registered-read RAM that holds dataOut during write cycles.
    always @(posedge clk) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
        else         ram_dataOut <= ram_mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] ref_mem [0:15];
    bit            ref_ok  [0:15];
    logic          g0, g1, last_g0, last_g1;
    logic          nxt_rv0, nxt_rv1, nxt_ok0, nxt_ok1;
    logic [DW-1:0] nxt_d0, nxt_d1;
    int            wait0, wait1, max0, max1;

    initial begin
        resetn     = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = 12'h123;
        bus.addr1  = 12'h456;
        bus.wdata0 = 32'hA5A5A5A5;
        bus.wdata1 = 32'h5A5A5A5A;
        #12;
        chk("rst_gnt0", 64'(bus.gnt0), 64'd0);
        chk("rst_gnt1", 64'(bus.gnt1), 64'd0);
        chk("rst_wen", 64'(ram_wEn), 64'd0);
        chk("rst_rvalid0", 64'(bus.rvalid0), 64'd0);
        chk("rst_rvalid1", 64'(bus.rvalid1), 64'd0);
        chk("rst_w1", 64'(dut.w1), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'h123);
        chk("rst_ram_din", 64'(ram_dataIn), 64'hA5A5A5A5);
        step();
        resetn = 1'b1;

        // Port 0 write then read of 0x010.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h010; bus.wdata0 = 32'hDEADBEEF;
        #1;
        chk("wr_gnt0", 64'(bus.gnt0), 64'd1);
        chk("wr_gnt1", 64'(bus.gnt1), 64'd0);
        chk("wr_wen", 64'(ram_wEn), 64'd1);
        chk("wr_addr", 64'(ram_addr), 64'h010);
        chk("wr_din", 64'(ram_dataIn), 64'hDEADBEEF);
        step();
        bus.we0 = 1'b0;
        #1;
        chk("rd_gnt0", 64'(bus.gnt0), 64'd1);
        chk("rd_wen", 64'(ram_wEn), 64'd0);
        chk("rd_rvalid_early", 64'(bus.rvalid0), 64'd0);
        step();
        bus.req0 = 1'b0;
        #1;
        chk("rd_rvalid0", 64'(bus.rvalid0), 64'd1);
        chk("rd_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        chk("rd_idle_gnt0", 64'(bus.gnt0), 64'd0);
        step();
        chk("rd_rvalid0_drop", 64'(bus.rvalid0), 64'd0);

        // Reset while a read is returning and both ports request.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h020;
        #1;
        chk("mr_gnt0", 64'(bus.gnt0), 64'd1);
        chk("mr_gnt1", 64'(bus.gnt1), 64'd0);
        step();
        chk("mr_rvalid_pre", 64'(bus.rvalid0), 64'd1);
        resetn = 1'b0;
        bus.we0 = 1'b1; bus.wdata0 = 32'hBAD0BAD0;
        #1;
        chk("mr_gnt0_rst", 64'(bus.gnt0), 64'd0);
        chk("mr_gnt1_rst", 64'(bus.gnt1), 64'd0);
        chk("mr_wen_rst", 64'(ram_wEn), 64'd0);
        chk("mr_rvalid0_rst", 64'(bus.rvalid0), 64'd0);
        chk("mr_w1_rst", 64'(dut.w1), 64'd0);
        step();
        chk("mr_wen_rst2", 64'(ram_wEn), 64'd0);
        chk("mr_rvalid0_rst2", 64'(bus.rvalid0), 64'd0);
        bus.we0 = 1'b0;
        resetn = 1'b1;
        #1;
        chk("mr_first_gnt0", 64'(bus.gnt0), 64'd1);
        chk("mr_first_gnt1", 64'(bus.gnt1), 64'd0);
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        #1;
        chk("mr_nowrite_rvalid", 64'(bus.rvalid0), 64'd1);
        chk("mr_nowrite_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        step();
        chk("mr_w1_clear", 64'(dut.w1), 64'd0);

        // Port 1 preloads 0x020.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h020; bus.wdata1 = 32'h12345678;
        #1;
        chk("pl_gnt1", 64'(bus.gnt1), 64'd1);
        chk("pl_wen", 64'(ram_wEn), 64'd1);
        chk("pl_addr", 64'(ram_addr), 64'h020);
        chk("pl_din", 64'(ram_dataIn), 64'h12345678);
        step();
        bus.req1 = 1'b0;
        #1;

        // Contention: req0 held, req1 forced through on the fifth cycle.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h030;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h040;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("ct_gnt0_c%0d", c), 64'(bus.gnt0), (c == 4) ? 64'd0 : 64'd1);
            chk($sformatf("ct_gnt1_c%0d", c), 64'(bus.gnt1), (c == 4) ? 64'd1 : 64'd0);
            if (c == 4) chk("ct_addr_c4", 64'(ram_addr), 64'h040);
            step();
            if (c == 3) chk("ct_w1_sat", 64'(dut.w1), 64'd4);
            if (c == 4) begin
                chk("ct_w1_after", 64'(dut.w1), 64'd0);
                bus.req1 = 1'b0;
                #1;
            end
        end
        bus.req0 = 1'b0;
        #1;
        step();

        // Port 1 read of 0x020 followed by port 0 write to 0x020.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h020;
        #1;
        chk("il_gnt1", 64'(bus.gnt1), 64'd1);
        step();
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h020; bus.wdata0 = 32'hFFFFFFFF;
        #1;
        chk("il_wr_gnt0", 64'(bus.gnt0), 64'd1);
        chk("il_wr_wen", 64'(ram_wEn), 64'd1);
        chk("il_rvalid1", 64'(bus.rvalid1), 64'd1);
        chk("il_rdata", 64'(bus.rdata), 64'h12345678);
        chk("il_rvalid0", 64'(bus.rvalid0), 64'd0);
        step();
        bus.we0 = 1'b0;
        #1;
        chk("il_rvalid1_drop", 64'(bus.rvalid1), 64'd0);
        chk("il_rd_gnt0", 64'(bus.gnt0), 64'd1);
        step();
        bus.req0 = 1'b0;
        #1;
        chk("il_rd_rvalid0", 64'(bus.rvalid0), 64'd1);
        chk("il_rd_rdata", 64'(bus.rdata), 64'hFFFFFFFF);
        step();

        // Idle request: req1 dropped after two denials restarts its wait.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h030;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h040;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("id_pre_gnt0_c%0d", c), 64'(bus.gnt0), 64'd1);
            step();
        end
        chk("id_w1_two", 64'(dut.w1), 64'd2);
        bus.req1 = 1'b0;
        #1;
        step();
        chk("id_w1_cleared", 64'(dut.w1), 64'd0);
        bus.req1 = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("id_gnt1_c%0d", c), 64'(bus.gnt1), (c == 4) ? 64'd1 : 64'd0);
            step();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        #1;
        step();

        // Random stress against a reference memory on addresses 0x100..0x10F.
        for (int i = 0; i < 16; i++) ref_ok[i] = 1'b0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        wait0 = 0; wait1 = 0; max0 = 0; max1 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.req0 || last_g0) begin
                bus.req0   = ($urandom_range(3) != 0);
                bus.we0    = 1'($urandom_range(1));
                bus.addr0  = 12'h100 + 12'($urandom_range(15));
                bus.wdata0 = $urandom;
            end
            if (!bus.req1 || last_g1) begin
                bus.req1   = ($urandom_range(3) != 0);
                bus.we1    = 1'($urandom_range(1));
                bus.addr1  = 12'h100 + 12'($urandom_range(15));
                bus.wdata1 = $urandom;
            end
            #1;
            g0 = bus.gnt0;
            g1 = bus.gnt1;
            chk("st_one_hot", 64'(g0 & g1), 64'd0);
            chk("st_work_conserving", 64'(g0 | g1), 64'(bus.req0 | bus.req1));
            if (bus.req0 && !g0) wait0++; else wait0 = 0;
            if (bus.req1 && !g1) wait1++; else wait1 = 0;
            if (wait0 > max0) max0 = wait0;
            if (wait1 > max1) max1 = wait1;
            nxt_rv0 = 1'b0; nxt_rv1 = 1'b0; nxt_ok0 = 1'b0; nxt_ok1 = 1'b0;
            nxt_d0 = '0; nxt_d1 = '0;
            if (g0) begin
                if (bus.we0) begin
                    ref_mem[bus.addr0[3:0]] = bus.wdata0;
                    ref_ok[bus.addr0[3:0]]  = 1'b1;
                end else begin
                    nxt_rv0 = 1'b1;
                    nxt_d0  = ref_mem[bus.addr0[3:0]];
                    nxt_ok0 = ref_ok[bus.addr0[3:0]];
                end
            end
            if (g1) begin
                if (bus.we1) begin
                    ref_mem[bus.addr1[3:0]] = bus.wdata1;
                    ref_ok[bus.addr1[3:0]]  = 1'b1;
                end else begin
                    nxt_rv1 = 1'b1;
                    nxt_d1  = ref_mem[bus.addr1[3:0]];
                    nxt_ok1 = ref_ok[bus.addr1[3:0]];
                end
            end
            last_g0 = g0;
            last_g1 = g1;
            step();
            chk("st_rvalid0", 64'(bus.rvalid0), 64'(nxt_rv0));
            chk("st_rvalid1", 64'(bus.rvalid1), 64'(nxt_rv1));
            if (nxt_rv0 && nxt_ok0) chk("st_rdata0", 64'(bus.rdata), 64'(nxt_d0));
            if (nxt_rv1 && nxt_ok1) chk("st_rdata1", 64'(bus.rdata), 64'(nxt_d1));
        end
        chk("st_max_wait0_ok", 64'(max0 <= 1), 64'd1);
        chk("st_max_wait1_ok", 64'(max1 <= MW), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the processor data port (port 0) and the game/display logic (port 1). Port 0 has fixed priority. Port 1 is protected from starvation by a bounded wait counter. The block muxes the winner's address, write enable and data onto the RAM. It returns read data to the winning port with a one-cycle-late valid strobe that matches the RAM's registered read.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDRESS_WIDTH, 12, RAM address width
- MAX_WAIT, 4, number of consecutive denied cycles for port 1 before it is forced to win (≥1)

- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request from port 0 / port 1; held with its command until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDRESS_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  combinational grant in the cycle the command reaches the RAM
- rvalid0 / rvalid1  out  1  registered; read data valid for that port
- rdata  out  DATA_WIDTH  shared read data, qualified by rvalid0/rvalid1
- ram_wEn  out  1  to RAM wEn
- ram_addr  out  ADDRESS_WIDTH  to RAM addr
- ram_dataIn  out  DATA_WIDTH  to RAM dataIn
- ram_dataOut  in  DATA_WIDTH  from RAM dataOut

## Operation
- Winner selection each cycle is combinational from req0, req1 and the registered wait count w1:
  - only req0 → port 0
  - only req1 → port 1
  - both and w1 < MAX_WAIT → port 0
  - both and w1 == MAX_WAIT → port 1
  - neither → no grant
- Exactly zero or one of gnt0/gnt1 is high. Under no circumstances are both high.
- RAM drive:
  - ram_addr, ram_dataIn = winner's addr/wdata.
  - ram_wEn = gnt & we of the winner.
  - With no grant: ram_wEn = 0 and ram_addr = addr0. The resulting RAM read is harmless because rvalid stays low.
- Wait counter w1, width $clog2(MAX_WAIT+1):
  - increments when req1 & ~gnt1
  - saturates at MAX_WAIT
  - clears to 0 on gnt1 or when req1 = 0
- Read return:
  - rvalid_k <= gnt_k & ~we_k.
  - rdata = ram_dataOut, a direct wire.
  - The RAM holds dataOut during write cycles, so a write granted after a read does not corrupt rdata in the rvalid cycle.
- A requester drops req or changes its command only after seeing its gnt high at a rising edge. A port may re-request back-to-back in the next cycle.
- While resetn = 0:
  - gnt0, gnt1, ram_wEn forced 0
  - rvalid0, rvalid1 = 0
  - w1 = 0
- Reset mid-operation: any pending rvalid is dropped. No write is issued during reset.

## Timing
- Grant latency: 0 cycles. gnt is high in the same cycle as req when that port wins.
- Read latency: rvalid and rdata are valid exactly 1 cycle after the granting cycle.
- Write: committed at the rising edge that ends the granting cycle.
- Throughput: one RAM access per cycle; no idle cycles between back-to-back grants.
- Starvation bound: under continuous req0, port 1 is granted no later than cycle MAX_WAIT+1 after it asserts req1.
  - Port 0 then waits at most 1 cycle before regaining priority.
- Reset values: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, ram_wEn = 0, w1 = 0. ram_addr and ram_dataIn follow port 0 inputs.

## Structure
- Shared package ram_arb_pkg holds:
  - port index constants PORT_CPU = 0, PORT_GAME = 1
  - default MAX_WAIT
- One sub-module, ram_arb_wait_counter: saturating counter with inc, clr and sat output, parameterised by MAX_WAIT.
- Everything else (winner logic, mux, rvalid registers) lives in ram_arbiter. Instantiate it beside RAM in the processor wrapper.

## Test plan
- Reset behaviour: assert resetn = 0 mid-read with req0 and req1 both high → gnt0 = gnt1 = ram_wEn = 0 immediately, rvalid0 = 0; after release, first grant goes to port 0.
- Single-port write then read: port 0 writes 0xDEADBEEF to addr 0x010, then reads 0x010 → gnt0 in each request cycle; rvalid0 one cycle after the read grant with rdata = 0xDEADBEEF.
- Contention with MAX_WAIT = 4: req0 held continuously, req1 asserted at cycle 0 → gnt0 in cycles 0–3, gnt1 in cycle 4, gnt0 in cycle 5; w1 back to 0 after cycle 4.
- Interleaved read then write: port 1 reads 0x020 (contents 0x12345678); in the next cycle port 0 writes 0xFFFFFFFF to 0x020 → rvalid1 = 1 with rdata = 0x12345678; a later read of 0x020 returns 0xFFFFFFFF.
- Idle request: req1 dropped after 2 denied cycles and re-asserted → w1 restarts from 0, and port 1 again waits the full MAX_WAIT cycles.
- Random stress: random req/we/addr on both ports against a reference memory model → read data always matches the model, gnt is never high on both ports, and no port is ever denied for more than MAX_WAIT+1 cycles.
